// File: rtl/usb_cdc_endp_router.sv
// rtl/usb_cdc_endp_router.sv - SIE endpoint router for one control endpoint plus CHANNELS CDC-ACM channels.
// Optional SERIAL_STATE notifier on the interrupt endpoints: define USB_CDC_NOTIFY_EN.
module usb_cdc_endp_router #(
    parameter int CHANNELS     = 2,
    parameter int CTRL_IF_BASE = 0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    usb_reset_i,
    input  logic [3:0]              endp_i,
    input  logic                    in_req_i,
    input  logic                    in_ready_i,
    input  logic                    out_ready_i,
    output logic [7:0]              in_data_o,
    output logic                    in_valid_o,
    output logic                    in_zlp_o,
    output logic                    out_nak_o,
    output logic                    stall_o,
    input  logic [7:0]              ctrl_in_data_i,
    input  logic                    ctrl_in_valid_i,
    input  logic                    ctrl_in_zlp_i,
    input  logic                    ctrl_stall_i,
    output logic                    ctrl_in_req_o,
    output logic                    ctrl_in_ready_o,
    output logic                    ctrl_out_ready_o,
    input  logic [8*CHANNELS-1:0]   bulk_in_data_i,
    input  logic [CHANNELS-1:0]     bulk_in_valid_i,
    input  logic [CHANNELS-1:0]     bulk_out_nak_i,
    output logic [CHANNELS-1:0]     bulk_in_req_o,
    output logic [CHANNELS-1:0]     bulk_in_ready_o,
    output logic [CHANNELS-1:0]     bulk_out_ready_o,
    input  logic                    halt_set_i,
    input  logic                    halt_clr_i,
    input  logic [3:0]              halt_endp_i,
    output logic [2*CHANNELS-1:0]   halt_o,
    input  logic [7*CHANNELS-1:0]   line_state_i
);

    localparam int         CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int         HW      = $clog2(2 * CHANNELS);
    localparam logic [3:0] LAST_EP = 4'(2 * CHANNELS);

    logic [3:0]            w_ep_idx;
    logic [CW-1:0]         w_ch_sel;
    logic                  w_is_ctrl;
    logic                  w_is_bulk;
    logic                  w_is_intr;
    logic                  w_halted;
    logic [3:0]            w_hep_idx;
    logic                  w_hep_mapped;
    logic [2*CHANNELS-1:0] r_halt;
    logic [7:0]            w_bulk_data;
    logic                  w_bulk_valid;
    logic                  w_bulk_nak;
    logic [7:0]            w_ntf_data;
    logic                  w_ntf_valid;
    logic                  w_unused;

    // Endpoint e maps to halt bit e-1 and channel (e-1)/2.
    assign w_ep_idx  = endp_i - 4'd1;
    assign w_ch_sel  = w_ep_idx[CW:1];
    assign w_is_ctrl = (endp_i == 4'd0);
    assign w_is_bulk = endp_i[0] && (endp_i <= LAST_EP);
    assign w_is_intr = !endp_i[0] && !w_is_ctrl && (endp_i <= LAST_EP);
    assign w_halted  = (w_is_bulk || w_is_intr) && r_halt[w_ep_idx[HW-1:0]];

    assign w_hep_idx    = halt_endp_i - 4'd1;
    assign w_hep_mapped = (halt_endp_i != 4'd0) && (halt_endp_i <= LAST_EP);
    assign w_unused     = ^{w_ep_idx, w_hep_idx};

    // Clear is applied after set so a simultaneous pair leaves the bit cleared.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_halt <= '0;
        end else if (usb_reset_i) begin
            r_halt <= '0;
        end else if (w_hep_mapped) begin
            if (halt_set_i) r_halt[w_hep_idx[HW-1:0]] <= 1'b1;
            if (halt_clr_i) r_halt[w_hep_idx[HW-1:0]] <= 1'b0;
        end
    end

    assign halt_o = r_halt;

    assign ctrl_in_req_o    = in_req_i    && w_is_ctrl;
    assign ctrl_in_ready_o  = in_ready_i  && w_is_ctrl;
    assign ctrl_out_ready_o = out_ready_i && w_is_ctrl;

    always_comb begin
        bulk_in_req_o    = '0;
        bulk_in_ready_o  = '0;
        bulk_out_ready_o = '0;
        w_bulk_data      = '0;
        w_bulk_valid     = 1'b0;
        w_bulk_nak       = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_ch_sel == CW'(k)) begin
                w_bulk_data  = bulk_in_data_i[8*k +: 8];
                w_bulk_valid = bulk_in_valid_i[k];
                w_bulk_nak   = bulk_out_nak_i[k];
                bulk_in_req_o[k]    = in_req_i    && w_is_bulk && !w_halted;
                bulk_in_ready_o[k]  = in_ready_i  && w_is_bulk && !w_halted;
                bulk_out_ready_o[k] = out_ready_i && w_is_bulk && !w_halted;
            end
        end
    end

    always_comb begin
        in_data_o  = 8'h00;
        in_valid_o = 1'b0;
        in_zlp_o   = 1'b0;
        stall_o    = 1'b0;
        out_nak_o  = 1'b1;
        if (w_is_ctrl) begin
            in_data_o  = ctrl_in_data_i;
            in_valid_o = ctrl_in_valid_i;
            in_zlp_o   = ctrl_in_zlp_i;
            stall_o    = ctrl_stall_i;
            out_nak_o  = 1'b0;
        end else if (w_is_bulk) begin
            in_data_o  = w_bulk_data;
            in_valid_o = w_bulk_valid;
            stall_o    = w_halted;
            out_nak_o  = w_bulk_nak;
        end else if (w_is_intr) begin
            in_data_o  = w_ntf_data;
            in_valid_o = w_ntf_valid;
            stall_o    = w_halted;
        end
    end

`ifdef USB_CDC_NOTIFY_EN
    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [6:0]            r_snapshot;
    logic [3:0]            r_idx;
    logic [CW-1:0]         r_chan;
    logic [7*CHANNELS-1:0] r_sent;
    logic [6:0]            w_line_sel;
    logic [6:0]            w_sent_sel;
    logic                  w_same;
    logic                  w_start;
    logic                  w_retry;
    logic                  w_abort;
    logic                  w_adv;
    logic                  w_last;
    logic [7:0]            w_windex;

    always_comb begin
        w_line_sel = '0;
        w_sent_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_ch_sel == CW'(k)) begin
                w_line_sel = line_state_i[7*k +: 7];
                w_sent_sel = r_sent[7*k +: 7];
            end
        end
    end

    // in_req_i outranks in_ready_i; any token elsewhere abandons the transfer.
    assign w_same  = w_is_intr && (w_ch_sel == r_chan);
    assign w_start = (r_state == S_IDLE) && in_req_i && w_is_intr && !w_halted
                     && (w_line_sel != w_sent_sel);
    assign w_retry = (r_state == S_SEND) && in_req_i && w_same && !w_halted;
    assign w_abort = (r_state == S_SEND) && (in_req_i || out_ready_i) && !w_same;
    assign w_adv   = (r_state == S_SEND) && in_ready_i && !in_req_i && w_same && !w_halted;
    assign w_last  = w_adv && (r_idx == 4'd9);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else if (usb_reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_SEND;
            S_SEND:  if (w_abort || w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_snapshot <= '0;
            r_idx      <= '0;
            r_chan     <= '0;
            r_sent     <= '0;
        end else if (usb_reset_i) begin
            r_idx  <= '0;
            r_sent <= '0;
        end else if (w_start) begin
            r_snapshot <= w_line_sel;
            r_chan     <= w_ch_sel;
            r_idx      <= '0;
        end else if (w_retry) begin
            r_idx <= '0;
        end else if (w_adv) begin
            if (w_last) begin
                r_idx <= '0;
                for (int k = 0; k < CHANNELS; k++) begin
                    if (r_chan == CW'(k)) r_sent[7*k +: 7] <= r_snapshot;
                end
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    assign w_windex = 8'(CTRL_IF_BASE + 2 * int'(r_chan));

    always_comb begin
        w_ntf_valid = (r_state == S_SEND) && w_same;
        case (r_idx)
            4'd0:    w_ntf_data = 8'hA1;
            4'd1:    w_ntf_data = 8'h20;
            4'd4:    w_ntf_data = w_windex;
            4'd6:    w_ntf_data = 8'h02;
            4'd8:    w_ntf_data = {1'b0, r_snapshot};
            default: w_ntf_data = 8'h00;
        endcase
    end
`else
    logic w_unused_line;

    assign w_ntf_valid   = 1'b0;
    assign w_ntf_data    = 8'h00;
    assign w_unused_line = ^line_state_i;
`endif

endmodule

// File: tb/tb_usb_cdc_endp_router.sv
// tb/tb_usb_cdc_endp_router.sv - directed self-checking bench for usb_cdc_endp_router (CHANNELS=2).
module tb_usb_cdc_endp_router;

    localparam int CH = 2;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              usb_reset_i;
    logic [3:0]        endp_i;
    logic              in_req_i, in_ready_i, out_ready_i;
    logic [7:0]        in_data_o;
    logic              in_valid_o, in_zlp_o, out_nak_o, stall_o;
    logic [7:0]        ctrl_in_data_i;
    logic              ctrl_in_valid_i, ctrl_in_zlp_i, ctrl_stall_i;
    logic              ctrl_in_req_o, ctrl_in_ready_o, ctrl_out_ready_o;
    logic [8*CH-1:0]   bulk_in_data_i;
    logic [CH-1:0]     bulk_in_valid_i, bulk_out_nak_i;
    logic [CH-1:0]     bulk_in_req_o, bulk_in_ready_o, bulk_out_ready_o;
    logic              halt_set_i, halt_clr_i;
    logic [3:0]        halt_endp_i;
    logic [2*CH-1:0]   halt_o;
    logic [7*CH-1:0]   line_state_i;

    int checks   = 0;
    int failures = 0;

    usb_cdc_endp_router #(.CHANNELS(CH), .CTRL_IF_BASE(0)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .usb_reset_i(usb_reset_i), .endp_i(endp_i),
        .in_req_i(in_req_i), .in_ready_i(in_ready_i), .out_ready_i(out_ready_i),
        .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_zlp_o(in_zlp_o),
        .out_nak_o(out_nak_o), .stall_o(stall_o),
        .ctrl_in_data_i(ctrl_in_data_i), .ctrl_in_valid_i(ctrl_in_valid_i),
        .ctrl_in_zlp_i(ctrl_in_zlp_i), .ctrl_stall_i(ctrl_stall_i),
        .ctrl_in_req_o(ctrl_in_req_o), .ctrl_in_ready_o(ctrl_in_ready_o),
        .ctrl_out_ready_o(ctrl_out_ready_o),
        .bulk_in_data_i(bulk_in_data_i), .bulk_in_valid_i(bulk_in_valid_i),
        .bulk_out_nak_i(bulk_out_nak_i), .bulk_in_req_o(bulk_in_req_o),
        .bulk_in_ready_o(bulk_in_ready_o), .bulk_out_ready_o(bulk_out_ready_o),
        .halt_set_i(halt_set_i), .halt_clr_i(halt_clr_i), .halt_endp_i(halt_endp_i),
        .halt_o(halt_o), .line_state_i(line_state_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] ep);
        endp_i   = ep;
        in_req_i = 1'b1;
        @(negedge clk_i);
        in_req_i = 1'b0;
        #1;
    endtask

    task automatic ready_n(input int n);
        for (int i = 0; i < n; i++) begin
            in_ready_i = 1'b1;
            @(negedge clk_i);
            in_ready_i = 1'b0;
        end
        #1;
    endtask

    task automatic halt_pulse(input logic set, input logic clr, input logic [3:0] ep);
        halt_set_i  = set;
        halt_clr_i  = clr;
        halt_endp_i = ep;
        @(negedge clk_i);
        halt_set_i  = 1'b0;
        halt_clr_i  = 1'b0;
        #1;
    endtask

`ifdef USB_CDC_NOTIFY_EN
    task automatic expect_notify(input string tag, input logic [7:0] e [0:9]);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 32'(in_valid_o), 32'd1);
            chk($sformatf("%s_byte%0d", tag, i), 32'(in_data_o), 32'(e[i]));
            in_ready_i = 1'b1;
            @(negedge clk_i);
            in_ready_i = 1'b0;
            #1;
        end
        chk({tag, "_done_valid"}, 32'(in_valid_o), 32'd0);
    endtask

    logic [7:0] exp_a [0:9] = '{8'hA1, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    logic [7:0] exp_b [0:9] = '{8'hA1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h41, 8'h00};
    logic [7:0] exp_c [0:9] = '{8'hA1, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h05, 8'h00};
`endif

    initial begin
        rstn_i = 1'b0; usb_reset_i = 1'b0; endp_i = 4'd0;
        in_req_i = 1'b0; in_ready_i = 1'b0; out_ready_i = 1'b0;
        ctrl_in_data_i = 8'h00; ctrl_in_valid_i = 1'b0; ctrl_in_zlp_i = 1'b0; ctrl_stall_i = 1'b0;
        bulk_in_data_i = '0; bulk_in_valid_i = '0; bulk_out_nak_i = '0;
        halt_set_i = 1'b0; halt_clr_i = 1'b0; halt_endp_i = 4'd0; line_state_i = '0;

        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_halt", 32'(halt_o), 32'd0);
        chk("rst_valid", 32'(in_valid_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_nak_ep0", 32'(out_nak_o), 32'd0);
        endp_i = 4'd7;
        #1;
        chk("rst_nak_ep7", 32'(out_nak_o), 32'd1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        endp_i = 4'd0;
        @(negedge clk_i);

        // Bulk channel 1 via endpoint 3
        endp_i = 4'd3; bulk_in_valid_i = 2'b10; bulk_in_data_i = 16'h5A00; bulk_out_nak_i = 2'b10;
        in_req_i = 1'b1;
        #1;
        chk("bulk3_req", 32'(bulk_in_req_o), 32'h2);
        chk("bulk3_data", 32'(in_data_o), 32'h5A);
        chk("bulk3_valid", 32'(in_valid_o), 32'd1);
        chk("bulk3_ctrl_req", 32'(ctrl_in_req_o), 32'd0);
        chk("bulk3_zlp", 32'(in_zlp_o), 32'd0);
        chk("bulk3_nak", 32'(out_nak_o), 32'd1);
        in_req_i = 1'b0; in_ready_i = 1'b1;
        #1;
        chk("bulk3_ready", 32'(bulk_in_ready_o), 32'h2);
        in_ready_i = 1'b0;

        // Bulk channel 0 via endpoint 1
        endp_i = 4'd1; out_ready_i = 1'b1;
        #1;
        chk("bulk1_oready", 32'(bulk_out_ready_o), 32'h1);
        chk("bulk1_valid", 32'(in_valid_o), 32'd0);
        chk("bulk1_data", 32'(in_data_o), 32'h00);
        chk("bulk1_nak", 32'(out_nak_o), 32'd0);
        out_ready_i = 1'b0;

        // Control endpoint pass-through
        endp_i = 4'd0; ctrl_in_data_i = 8'hC3; ctrl_in_valid_i = 1'b1; ctrl_stall_i = 1'b1;
        in_req_i = 1'b1;
        #1;
        chk("ctrl_req", 32'(ctrl_in_req_o), 32'd1);
        chk("ctrl_data", 32'(in_data_o), 32'hC3);
        chk("ctrl_stall", 32'(stall_o), 32'd1);
        chk("ctrl_bulk_req", 32'(bulk_in_req_o), 32'd0);
        in_req_i = 1'b0;
        @(negedge clk_i);

        // Halt on endpoint 1
        halt_set_i = 1'b1; halt_endp_i = 4'd1;
        #1;
        chk("halt_before_edge", 32'(halt_o), 32'd0);
        @(negedge clk_i);
        halt_set_i = 1'b0;
        #1;
        chk("halt_ep1_set", 32'(halt_o), 32'b0001);
        endp_i = 4'd1; in_req_i = 1'b1;
        #1;
        chk("halt_ep1_stall", 32'(stall_o), 32'd1);
        chk("halt_ep1_req", 32'(bulk_in_req_o), 32'd0);
        endp_i = 4'd3;
        #1;
        chk("ep3_not_halted_req", 32'(bulk_in_req_o), 32'h2);
        chk("ep3_not_halted_stall", 32'(stall_o), 32'd0);
        in_req_i = 1'b0;
        halt_pulse(1'b1, 1'b1, 4'd1);
        chk("halt_set_clr", 32'(halt_o), 32'd0);
        halt_pulse(1'b1, 1'b0, 4'd0);
        chk("halt_ep0_ignored", 32'(halt_o), 32'd0);
        halt_pulse(1'b1, 1'b0, 4'd7);
        chk("halt_ep7_ignored", 32'(halt_o), 32'd0);
        halt_pulse(1'b1, 1'b0, 4'd4);
        chk("halt_ep4_set", 32'(halt_o), 32'b1000);
        endp_i = 4'd4;
        #1;
        chk("halt_ep4_stall", 32'(stall_o), 32'd1);
        usb_reset_i = 1'b1;
        @(negedge clk_i);
        usb_reset_i = 1'b0;
        #1;
        chk("usbrst_halt", 32'(halt_o), 32'd0);

        // Unmapped endpoint
        endp_i = 4'd7; in_req_i = 1'b1; in_ready_i = 1'b1; out_ready_i = 1'b1;
        #1;
        chk("ep7_bulk_req", 32'(bulk_in_req_o), 32'd0);
        chk("ep7_bulk_oready", 32'(bulk_out_ready_o), 32'd0);
        chk("ep7_ctrl_req", 32'(ctrl_in_req_o), 32'd0);
        chk("ep7_ctrl_oready", 32'(ctrl_out_ready_o), 32'd0);
        chk("ep7_nak", 32'(out_nak_o), 32'd1);
        chk("ep7_stall", 32'(stall_o), 32'd0);
        chk("ep7_valid", 32'(in_valid_o), 32'd0);
        in_req_i = 1'b0; in_ready_i = 1'b0; out_ready_i = 1'b0;
        ctrl_stall_i = 1'b0;
        @(negedge clk_i);

`ifdef USB_CDC_NOTIFY_EN
        line_state_i = {7'h03, 7'h00};
        req(4'd4);
        expect_notify("ntf_ch1", exp_a);
        req(4'd4);
        chk("ntf_ch1_nak_after", 32'(in_valid_o), 32'd0);

        line_state_i = {7'h03, 7'h41};
        req(4'd2);
        chk("retry_byte0", 32'(in_data_o), 32'hA1);
        ready_n(5);
        chk("retry_byte5", 32'(in_data_o), 32'h00);
        req(4'd2);
        chk("retry_restart", 32'(in_data_o), 32'hA1);
        chk("retry_valid", 32'(in_valid_o), 32'd1);
        ready_n(1);
        chk("retry_byte1", 32'(in_data_o), 32'h20);
        req(4'd1);
        endp_i = 4'd2;
        #1;
        chk("abort_valid", 32'(in_valid_o), 32'd0);
        req(4'd2);
        expect_notify("ntf_ch0", exp_b);

        line_state_i = {7'h05, 7'h41};
        req(4'd4);
        ready_n(3);
        chk("mid_send_byte3", 32'(in_data_o), 32'h00);
        halt_pulse(1'b1, 1'b0, 4'd3);
        usb_reset_i = 1'b1;
        @(negedge clk_i);
        usb_reset_i = 1'b0;
        #1;
        chk("usbrst_send_valid", 32'(in_valid_o), 32'd0);
        chk("usbrst_send_halt", 32'(halt_o), 32'd0);
        req(4'd4);
        expect_notify("ntf_resend", exp_c);
`else
        line_state_i = {7'h03, 7'h41};
        req(4'd4);
        chk("intr_nak_valid", 32'(in_valid_o), 32'd0);
        chk("intr_nak_zlp", 32'(in_zlp_o), 32'd0);
        chk("intr_nak_stall", 32'(stall_o), 32'd0);
        req(4'd2);
        chk("intr2_nak_valid", 32'(in_valid_o), 32'd0);
        halt_pulse(1'b1, 1'b0, 4'd2);
        chk("intr2_halt", 32'(halt_o), 32'b0010);
        chk("intr2_stall", 32'(stall_o), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_cdc_endp_router.md
# usb_cdc_endp_router

Parametrised endpoint router between the SIE and a control endpoint plus CHANNELS CDC-ACM channels, each channel owning one bulk endpoint pair and one interrupt IN endpoint. It steers SIE requests and strobes to the addressed endpoint. It muxes the response back to the SIE and holds per-endpoint halt (STALL) state. It optionally generates CDC SERIAL_STATE notifications on each interrupt endpoint. It replaces the fixed single-channel endpoint steering in the CDC top level.

## Interface
- CHANNELS, 2, number of CDC channels, 1..4; channel k uses bulk endpoint 2k+1 and interrupt endpoint 2k+2.
- CTRL_IF_BASE, 0, interface number of channel 0's communication interface; channel k reports wIndex = CTRL_IF_BASE+2k.
- clk_i  in  1  system clock, 12MHz*BIT_SAMPLES.
- rstn_i  in  1  reset, asynchronous, active-low.
- usb_reset_i  in  1  USB bus reset pulse from the SIE.
- endp_i  in  4  current endpoint from the SIE.
- in_req_i / in_ready_i / out_ready_i  in  1  SIE IN-token pulse, IN byte-consumed strobe, OUT byte strobe.
- in_data_o  out  8  IN byte to the SIE.
- in_valid_o / in_zlp_o / out_nak_o / stall_o  out  1  responses to the SIE.
- ctrl_in_data_i  in  8  control endpoint IN byte.
- ctrl_in_valid_i / ctrl_in_zlp_i / ctrl_stall_i  in  1  control endpoint responses.
- ctrl_in_req_o / ctrl_in_ready_o / ctrl_out_ready_o  out  1  gated SIE strobes to the control endpoint.
- bulk_in_data_i  in  8*CHANNELS  packed bulk IN bytes; channel k is at [8k+7:8k].
- bulk_in_valid_i / bulk_out_nak_i  in  CHANNELS  per-channel bulk responses.
- bulk_in_req_o / bulk_in_ready_o / bulk_out_ready_o  out  CHANNELS  gated strobes, one-hot or zero.
- halt_set_i / halt_clr_i  in  1  SET_FEATURE/CLEAR_FEATURE ENDPOINT_HALT pulses from the control endpoint.
- halt_endp_i  in  4  endpoint targeted by a halt pulse.
- halt_o  out  2*CHANNELS  halt bits; bit 2k is bulk endpoint 2k+1, bit 2k+1 is interrupt endpoint 2k+2.
- line_state_i  in  7*CHANNELS  per-channel SERIAL_STATE bitmap bits 6:0: DCD, DSR, break, ring, framing, parity, overrun.

## Operation
- Routing is combinational on endp_i. Strobes reach only the addressed endpoint; every other strobe is 0.
- Endpoint 0: ctrl_* pass straight through. out_nak_o=0.
- Bulk endpoint 2k+1: in_data_o and in_valid_o come from channel k. in_zlp_o=0. out_nak_o=bulk_out_nak_i[k].
- Interrupt endpoint 2k+2: driven by the notifier. If that is compiled out, the endpoint NAKs: in_valid_o=0, in_zlp_o=0.
- Unmapped endpoints (above 2*CHANNELS): all strobes 0, in_valid_o=0, in_zlp_o=0, stall_o=0, out_nak_o=1.
- Halt: halt_set_i sets the bit of halt_endp_i and halt_clr_i clears it. If both pulse together, clear wins.
- Halt pulses naming endpoint 0 or an unmapped endpoint are ignored.
- A halted endpoint gives stall_o=1, and its req/ready strobes are suppressed. The data toggle reset stays with the control endpoint.
- Notifier state, shared by all channels because only one transaction is active at a time:
  - pending[k] is set while line_state_i[k] differs from sent[k].
  - Registers: snapshot (7 bits), idx (4 bits), busy, chan.
- Notifier states IDLE and SEND:
  - IDLE -> SEND on in_req_i at interrupt endpoint k with pending[k] set and not halted. This loads snapshot=line_state_i[k], chan=k, idx=0.
  - An in_req_i with pending[k] clear stays in IDLE; the endpoint NAKs.
- SEND behaviour:
  - in_valid_o=1 with byte idx of: A1 20 00 00 wIndex 00 02 00 {0,snapshot} 00.
  - Each in_ready_i increments idx.
  - The in_ready_i on idx=9 sets sent[chan]=snapshot, deasserts in_valid_o and returns to IDLE.
  - A new in_req_i on the same endpoint while in SEND is a host retry: idx=0, snapshot is kept.
  - A token to any other endpoint while in SEND aborts to IDLE; sent[] is unchanged, so the notification stays pending.
- usb_reset_i clears halt_o, sent[], idx and busy, and returns the notifier to IDLE.
- A line-state change during SEND does not alter the snapshot in flight. pending re-asserts after completion.

## Timing
- Routing and response muxing have zero-cycle latency.
- Halt bits and notifier registers update on the clk_i edge after their pulse.
- On reset, all outputs are 0 except out_nak_o, which follows the endpoint decode for endp_i.
- Registers reset to 0: halt_o, sent[], snapshot, idx, and the IDLE state.
- Any nonzero line_state_i after reset is pending.
- in_req_i and in_ready_i are single-cycle pulses. When both arrive in the same cycle, in_req_i has priority.

## Configuration
- USB_CDC_NOTIFY_EN defined: the notifier is built and interrupt endpoints send SERIAL_STATE.
- USB_CDC_NOTIFY_EN undefined: the notifier, sent[] and snapshot are removed. Interrupt endpoints NAK every IN, but halt still applies to them.

## Test plan
- CHANNELS=2, endp_i=3 with bulk_in_valid_i=2'b10, bulk_in_data_i[15:8]=8'h5A, pulse in_req_i -> bulk_in_req_o=2'b10, in_data_o=8'h5A, in_valid_o=1, ctrl_in_req_o=0.
- halt_set_i with halt_endp_i=1 -> halt_o=4'b0001 next cycle, and IN on endpoint 1 gives stall_o=1 with bulk_in_req_o=0. halt_set_i and halt_clr_i together -> bit cleared.
- Notify on, CTRL_IF_BASE=0, line_state_i[13:7]=7'h03, IN on endpoint 4 with 10 in_ready_i pulses -> bytes A1 20 00 00 02 00 02 00 03 00, then in_valid_o=0 and a further IN NAKs.
- Retry: in_req_i on endpoint 2 after 5 of 10 bytes -> idx restarts and byte 0 is A1. Abort via token to endpoint 1 -> notification still pending.
- usb_reset_i mid-SEND -> IDLE, halt_o=0. A nonzero line state is re-sent from byte 0.
- endp_i=7 with CHANNELS=2 -> all strobes 0, out_nak_o=1, stall_o=0.
